// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and constants.
// Imported by the key-schedule controller and its key store.
package aes_pkg;

  localparam int AES_KEY_LEN   = 128;
  localparam int AES128_ROUNDS = 10;

  typedef logic [3:0] rnd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FINISH
  } state_e;

endpackage

// File: rtl/aes_round_key_store.sv
// Round-key register file: one write port, one registered read port,
// plus a combinational tap feeding the previous key to the generator.
module aes_round_key_store
  import aes_pkg::*;
#(
  parameter int KEY_LEN = AES_KEY_LEN,
  parameter int DEPTH   = AES128_ROUNDS + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  rnd_t               waddr,
  input  logic [KEY_LEN-1:0] wdata,
  input  logic               re,
  input  rnd_t               raddr,
  output logic [KEY_LEN-1:0] rdata,
  input  rnd_t               peek_addr,
  output logic [KEY_LEN-1:0] peek_data
);

  logic [KEY_LEN-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rdata <= '0;
    else if (re)
      rdata <= mem[raddr];
  end

  assign peek_data = mem[peek_addr];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: drives the shared round-key
// generator round by round and serves the stored schedule.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_LEN    = AES_KEY_LEN,
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int GEN_SETTLE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_LEN-1:0] cipher_key,
  output logic               busy,
  output logic               done,
  output logic               keys_ready,
  input  logic               rd_en,
  input  rnd_t               rd_addr,
  output logic [KEY_LEN-1:0] rd_data,
  output logic               rd_valid,
  output logic               rd_err,
  output rnd_t               gen_round_n,
  output logic [KEY_LEN-1:0] gen_data_in,
  output logic               gen_valid_in,
  input  logic [KEY_LEN-1:0] gen_data_out,
  input  logic               gen_valid_out
);

  localparam rnd_t       LAST_RND = rnd_t'(NUM_ROUNDS - 1);
  localparam rnd_t       MAX_ADDR = rnd_t'(NUM_ROUNDS);
  localparam logic [3:0] SETTLE_M1 = 4'(GEN_SETTLE - 1);

  state_e             state, nxt;
  rnd_t               rnd, rnd_n;
  logic [3:0]         pcnt, pcnt_n;
  logic               kr_n;
  logic               we;
  rnd_t               waddr;
  logic [KEY_LEN-1:0] wdata;
  logic [KEY_LEN-1:0] prev_key;
  logic               rd_ok;

  assign rd_ok = rd_en && keys_ready && (rd_addr <= MAX_ADDR);

  aes_round_key_store #(
    .KEY_LEN (KEY_LEN),
    .DEPTH   (NUM_ROUNDS + 1)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re        (rd_ok),
    .raddr     (rd_addr),
    .rdata     (rd_data),
    .peek_addr (rnd),
    .peek_data (prev_key)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rnd        <= '0;
      pcnt       <= '0;
      keys_ready <= 1'b0;
    end else begin
      state      <= nxt;
      rnd        <= rnd_n;
      pcnt       <= pcnt_n;
      keys_ready <= kr_n;
    end
  end

  always_comb begin
    nxt          = state;
    rnd_n        = rnd;
    pcnt_n       = pcnt;
    kr_n         = keys_ready;
    we           = 1'b0;
    waddr        = '0;
    wdata        = '0;
    busy         = 1'b0;
    done         = 1'b0;
    gen_valid_in = 1'b0;
    gen_round_n  = '0;
    gen_data_in  = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          we     = 1'b1;
          wdata  = cipher_key;
          kr_n   = 1'b0;
          rnd_n  = '0;
          pcnt_n = '0;
          nxt    = ISSUE;
        end
      end
      ISSUE: begin
        busy         = 1'b1;
        gen_valid_in = 1'b1;
        gen_round_n  = rnd;
        gen_data_in  = prev_key;
        // earlier strobes are pipeline fill, only the settled one counts
        if (gen_valid_out) begin
          if (pcnt == SETTLE_M1) begin
            we    = 1'b1;
            waddr = rnd + rnd_t'(1);
            wdata = gen_data_out;
            nxt   = DRAIN;
          end else begin
            pcnt_n = pcnt + 4'd1;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!gen_valid_out) begin
          pcnt_n = '0;
          if (rnd == LAST_RND) begin
            nxt = FINISH;
          end else begin
            rnd_n = rnd + rnd_t'(1);
            nxt   = ISSUE;
          end
        end
      end
      FINISH: begin
        done = 1'b1;
        kr_n = 1'b1;
        nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_err   <= rd_en && !rd_ok;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES-128 round-key generator
// with programmable strobe trains, and a read-response scoreboard.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy, done, keys_ready;
  logic         rd_en;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;
  logic         rd_valid, rd_err;
  logic [3:0]   gen_round_n;
  logic [127:0] gen_data_in;
  logic         gen_valid_in;
  logic [127:0] gen_data_out;
  logic         gen_valid_out;

  aes_key_sched_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cipher_key    (cipher_key),
    .busy          (busy),
    .done          (done),
    .keys_ready    (keys_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_err        (rd_err),
    .gen_round_n   (gen_round_n),
    .gen_data_in   (gen_data_in),
    .gen_valid_in  (gen_valid_in),
    .gen_data_out  (gen_data_out),
    .gen_valid_out (gen_valid_out)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // AES reference arithmetic
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_next(input logic [127:0] k,
                                            input logic [3:0] rn);
    logic [7:0]  rc;
    logic [31:0] t, w0, w1, w2, w3;
    rc = 8'h01;
    for (int i = 0; i < int'(rn); i++) rc = gm(rc, 8'h02);
    t = {k[23:0], k[31:24]};
    t = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // generator model: strobe train by mask, good data at the 2nd strobe
  logic [7:0]   mask;
  logic [3:0]   gpos;
  logic [3:0]   pos;
  logic         armed;
  logic         good_out;
  logic [127:0] good;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos           <= 4'd0;
      armed         <= 1'b1;
      good_out      <= 1'b0;
      good          <= '0;
      gen_valid_out <= 1'b0;
      gen_data_out  <= '0;
    end else begin
      if (!gen_valid_in) armed <= 1'b1;
      if (pos == 4'd0) begin
        gen_valid_out <= 1'b0;
        good_out      <= 1'b0;
        if (gen_valid_in && armed) begin
          pos   <= 4'd1;
          armed <= 1'b0;
          good  <= aes_next(gen_data_in, gen_round_n);
        end
      end else begin
        gen_valid_out <= mask[3'(pos - 4'd1)];
        good_out      <= (pos == gpos);
        gen_data_out  <= (pos == gpos) ? good : good ^ {4'h0, pos, 120'h0};
        pos           <= (pos == 4'd8) ? 4'd0 : pos + 4'd1;
      end
    end
  end

  // monitors: done count, issue ordering, request drop after capture
  int   n_done = 0;
  int   exp_rn = 0;
  logic prev_vin = 1'b0;
  logic prev_vo  = 1'b0;
  logic was_good = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (done) n_done <= n_done + 1;
      if (!busy) exp_rn <= 0;
      if (gen_valid_in && !prev_vin) begin
        check("issue_rn", gen_round_n, 128'(exp_rn));
        check("issue_vo_low", prev_vo, 0);
        exp_rn <= exp_rn + 1;
      end
      if (was_good) check("vin_drop", gen_valid_in, 0);
    end
    prev_vin <= gen_valid_in;
    prev_vo  <= gen_valid_out;
    was_good <= good_out;
  end

  // read scoreboard
  typedef struct {
    logic         ok;
    logic [127:0] data;
  } rexp_t;

  rexp_t        sbq[$];
  logic [127:0] last_data = '0;
  logic [127:0] exp_keys [11];

  task automatic rd(input string tag, input logic [3:0] a, input logic ok,
                    input logic [127:0] d);
    rexp_t e;
    e.ok   = ok;
    e.data = ok ? d : last_data;
    if (ok) last_data = d;
    sbq.push_back(e);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    e = sbq.pop_front();
    check({tag, "_valid"}, rd_valid, e.ok);
    check({tag, "_err"}, rd_err, !e.ok);
    check({tag, "_data"}, rd_data, e.data);
  endtask

  int nd0;

  task automatic kick(input logic [127:0] k);
    exp_keys[0] = k;
    for (int r = 0; r < 10; r++) exp_keys[r+1] = aes_next(exp_keys[r], 4'(r));
    nd0        = n_done;
    start      = 1'b1;
    cipher_key = k;
    @(negedge clk);
    start = 1'b0;
    check("kick_busy", busy, 1);
    check("kick_kr_drop", keys_ready, 0);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 3000 && !done; i++) @(negedge clk);
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int i;
    for (i = 0; i < 3000 && !(gen_valid_in && gen_round_n == r); i++)
      @(negedge clk);
    if (!(gen_valid_in && gen_round_n == r)) check("round_timeout", 0, 1);
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r <= 10; r++) rd(tag, 4'(r), 1'b1, exp_keys[r]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    cipher_key = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    mask       = 8'b0000_1010;
    gpos       = 4'd4;
    repeat (3) @(negedge clk);
    check("rst_ctl", {busy, done, keys_ready, rd_valid, rd_err,
                      gen_valid_in, gen_round_n}, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_gen_data", gen_data_in, 0);
    reset = 1'b1;
    @(negedge clk);
    rd("rd_unexpanded", 4'd0, 1'b0, '0);

    // FIPS-197 key with reference generator
    kick(FIPS_KEY);
    wait_done();
    rd("rd_in_finish", 4'd1, 1'b0, '0);
    check("fips_kr", keys_ready, 1);
    check("fips_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("fips_done_once", 32'(n_done - nd0), 1);
    rd("fips_r1", 4'd1, 1'b1, FIPS_R1);
    rd("fips_r10", 4'd10, 1'b1, FIPS_R10);
    rd("fips_r0", 4'd0, 1'b1, FIPS_KEY);
    read_all("fips_all");

    // three strobes per request, start ignored while busy
    mask = 8'b0000_1101;
    gpos = 4'd3;
    kick(128'h000102030405060708090a0b0c0d0e0f);
    wait_round(4'd4);
    start      = 1'b1;
    cipher_key = 128'hdeadbeef_00000000_cafef00d_12345678;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_kept", busy, 1);
    wait_done();
    repeat (2) @(negedge clk);
    check("stub_done_once", 32'(n_done - nd0), 1);
    rd("rd_addr11", 4'd11, 1'b0, '0);
    rd("rd_addr15", 4'd15, 1'b0, '0);
    read_all("stub_all");

    // reset mid-expansion
    mask = 8'b0000_1010;
    gpos = 4'd4;
    kick(FIPS_KEY);
    wait_round(4'd6);
    reset = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_kr", keys_ready, 0);
    check("midrst_rd_data", rd_data, 0);
    last_data = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd("midrst_rd0", 4'd0, 1'b0, '0);

    // strobe held high across the drain phase
    mask = 8'b0011_1111;
    gpos = 4'd2;
    kick(FIPS_KEY);
    rd("rd_while_busy", 4'd0, 1'b0, '0);
    wait_done();
    @(negedge clk);
    rd("held_r10", 4'd10, 1'b1, FIPS_R10);
    rd("held_r5", 4'd5, 1'b1, exp_keys[5]);
    rd("held_r0", 4'd0, 1'b1, FIPS_KEY);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequences the shared single-round subkey generator (one round key per request: previous key plus round index in, next key out) through a full AES-128 key expansion.
- Stores cipher key plus all round keys in an internal key store and serves round keys to the cipher datapath through a 1-cycle read port.
- Sits between top-level key load and the round pipeline. Owns the generator's valid_in, data_in and round_n.

Parameters:
- KEY_LEN, 128, key / round-key width in bits.
- NUM_ROUNDS, 10, number of generated round keys. Store depth is NUM_ROUNDS+1.
- GEN_SETTLE, 2, ordinal of the generator valid_out pulse captured per round. Earlier pulses are pipeline-fill garbage and are discarded.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  1-cycle pulse; begin expansion of cipher_key
- cipher_key  in  KEY_LEN  round-0 key, sampled in the start cycle
- busy  out  1  expansion in progress
- done  out  1  1-cycle pulse when the last round key is stored
- keys_ready  out  1  store holds a complete valid schedule
- rd_en  in  1  read request
- rd_addr  in  4  round index 0..NUM_ROUNDS
- rd_data  out  KEY_LEN  round key, valid with rd_valid
- rd_valid  out  1  read response, 1 cycle after rd_en
- rd_err  out  1  1-cycle pulse: read refused
- gen_round_n  out  4  round index to generator
- gen_data_in  out  KEY_LEN  previous round key to generator
- gen_valid_in  out  1  generator request
- gen_data_out  in  KEY_LEN  generated key
- gen_valid_out  in  1  generator result strobe

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, key store cleared, round counter 0, pulse counter 0.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - On start, write cipher_key to store[0], clear keys_ready, set rnd=0, go to ISSUE next cycle.
  - start while busy is ignored.
- ISSUE:
  - gen_valid_in=1; gen_data_in=store[rnd]; gen_round_n=rnd. Generator Rcon mapping: round_n=0 yields round-1 key.
  - Inputs are held stable the whole state.
  - Count gen_valid_out pulses. On pulse number GEN_SETTLE, write gen_data_out to store[rnd+1] and go to DRAIN.
- DRAIN:
  - gen_valid_in=0.
  - Wait until gen_valid_out is sampled 0 for one cycle, then clear the pulse counter.
  - If rnd+1==NUM_ROUNDS, go to FINISH. Else rnd++ and go to ISSUE.
  - Any gen_valid_out in DRAIN is discarded.
- FINISH: done=1 and keys_ready=1 (registered), return to IDLE. busy=0 from this cycle.
- busy=1 in ISSUE and DRAIN, and in the cycle after start is accepted.
- Read port:
  - rd_en with keys_ready=1 and rd_addr<=NUM_ROUNDS: next cycle rd_valid=1, rd_data=store[rd_addr].
  - Otherwise (busy, never expanded, or addr out of range): next cycle rd_valid=0, rd_err=1, rd_data holds its previous value.
- Simultaneous read and FINISH: keys_ready is registered, so a read issued in the FINISH cycle is refused.
- Reset mid-expansion: immediate return to IDLE, store cleared, keys_ready=0. The generator is reset by the same net.
- New start after completion: keys_ready drops in the start cycle+1; old keys are not readable during re-expansion.

Decomposition:
- Shared package aes_pkg: AES_KEY_LEN=128, AES128_ROUNDS=10, FSM state enum, round-index typedef (4 bits).
- Sub-module aes_round_key_store: (NUM_ROUNDS+1)xKEY_LEN register file. One write port (controller), one registered read port, async clear.

Test Plan:
- Reset, then rd_en with rd_addr=0 -> rd_valid=0, rd_err=1; all outputs 0 during reset.
- Reference generator connected; cipher_key=2b7e151628aed2a6abf7158809cf4f3c; start.
  - done pulses once, keys_ready=1.
  - rd_addr=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_addr=0 -> the cipher key.
- Generator stub emits 3 valid_out pulses per request with distinct data -> only the 2nd pulse's data is stored; gen_valid_in deasserts the cycle after capture.
- start pulsed again at round 4 -> ignored. Afterwards rd_addr=11 -> rd_err=1 and rd_data unchanged.
- reset asserted during round 6 -> busy=0, keys_ready=0, store reads as 0 after a fresh start. Re-run of the FIPS key reproduces the round-10 key.
- Gen_valid_out held 1 across DRAIN -> controller stalls in DRAIN until it drops, then issues round rnd+1 with round_n incremented by exactly 1.
